timer_bank: RTL and testbench

Parametrised multi-channel timer/counter peripheral, the next generation of the board's fixed three-channel counter. It provides NUM_CH independent down-counters, all on the single system clock, each with its own programmable prescaler. Each channel runs in one of four modes: one-shot, auto-reload, PWM or square-wave. The bank attaches to the MIO bus peripheral write port. It drives per-channel outputs, plus a single level interrupt for the CPU INT input.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/timer_bank_if.sv | 10 +
 rtl/timer_channel.sv | 115 +++++++++++
 rtl/timer_bank.sv | 66 ++++++
 tb/tb_timer_bank.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - mode encodings and register layout shared by the timer bank
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_SQUARE  = 2'd3
  } mode_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;
  localparam logic [1:0] REG_STATUS = 2'd0;

  localparam logic [2:0] GLOBAL_CHAN = 3'd7;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_MODE_LSB   = 1;
  localparam int CTRL_IRQ_EN_BIT = 3;
  localparam int CTRL_PSC_LSB    = 8;

endpackage

// File: rtl/timer_bank_if.sv
// rtl/timer_bank_if.sv - peripheral register port of the timer bank
interface timer_bank_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counter with prescaler, mode logic and output
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        term,
  output logic        irq_en,
  output logic        cnt_out
);

  logic             en;
  mode_e            mode;
  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_cnt;
  logic [CNT_W-1:0] load;
  logic [CNT_W-1:0] cmp;
  logic [CNT_W-1:0] count;
  logic             pulse;
  logic             sq;

  logic             ctrl_we;
  logic             load_we;
  logic             cmp_we;
  logic             tick;
  logic [CNT_W-1:0] reload_val;
  logic             unused_wdata;

  assign ctrl_we = we && (reg_sel == REG_CTRL);
  assign load_we = we && (reg_sel == REG_LOAD);
  assign cmp_we  = we && (reg_sel == REG_CMP);
  assign tick    = en && (psc_cnt == psc);
  // A CTRL write in the same cycle swallows the tick entirely.
  assign term    = tick && (count == '0) && !ctrl_we;
  assign reload_val = load_we ? wdata[CNT_W-1:0] : load;
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      mode    <= MODE_ONESHOT;
      irq_en  <= 1'b0;
      psc     <= '0;
      psc_cnt <= '0;
      load    <= '0;
      cmp     <= '0;
      count   <= '0;
      pulse   <= 1'b0;
      sq      <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (load_we) load <= wdata[CNT_W-1:0];
      if (cmp_we)  cmp  <= wdata[CNT_W-1:0];
      if (ctrl_we) begin
        en      <= wdata[CTRL_EN_BIT];
        mode    <= mode_e'(wdata[CTRL_MODE_LSB +: 2]);
        irq_en  <= wdata[CTRL_IRQ_EN_BIT];
        psc     <= wdata[CTRL_PSC_LSB +: PSC_W];
        psc_cnt <= '0;
        sq      <= 1'b0;
        if (!en && wdata[CTRL_EN_BIT]) count <= load;
      end else if (en) begin
        psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
        if (tick) begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            // One-shot parks at zero and disables; the others reload.
            if (mode == MODE_ONESHOT) en <= 1'b0;
            else                      count <= reload_val;
            if (mode == MODE_ONESHOT || mode == MODE_RELOAD) pulse <= 1'b1;
            if (mode == MODE_SQUARE) sq <= ~sq;
          end
        end
      end else begin
        psc_cnt <= '0;
        sq      <= 1'b0;
      end
    end
  end

  always_comb begin
    cnt_out = 1'b0;
    case (mode)
      MODE_ONESHOT, MODE_RELOAD: cnt_out = pulse;
      MODE_PWM:                  cnt_out = en && (count < cmp);
      MODE_SQUARE:               cnt_out = en && sq;
      default:                   cnt_out = 1'b0;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN_BIT]               = en;
        rdata[CTRL_MODE_LSB +: 2]        = mode;
        rdata[CTRL_IRQ_EN_BIT]           = irq_en;
        rdata[CTRL_PSC_LSB +: PSC_W]     = psc;
      end
      REG_LOAD:  rdata[CNT_W-1:0] = load;
      REG_CMP:   rdata[CNT_W-1:0] = cmp;
      REG_COUNT: rdata[CNT_W-1:0] = count;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel timer bank: decode, STATUS, read mux and irq
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  timer_bank_if.slave       bus,
  output logic [NUM_CH-1:0] cnt_out,
  output logic              irq
);

  logic [2:0]        chan;
  logic [1:0]        rsel;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] status_clr;
  logic [31:0]       ch_rdata [NUM_CH];

  assign chan = bus.addr[4:2];
  assign rsel = bus.addr[1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W (CNT_W),
      .PSC_W (PSC_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .we      (bus.we && (chan == 3'(g))),
      .reg_sel (rsel),
      .wdata   (bus.wdata),
      .rdata   (ch_rdata[g]),
      .term    (term[g]),
      .irq_en  (irq_en[g]),
      .cnt_out (cnt_out[g])
    );
  end

  assign status_clr = (bus.we && chan == GLOBAL_CHAN && rsel == REG_STATUS)
                    ? bus.wdata[NUM_CH-1:0] : '0;

  // New terminal events override a simultaneous write-1-clear.
  always_ff @(posedge clk) begin
    if (rst) status <= '0;
    else     status <= (status & ~status_clr) | term;
  end

  assign irq = |(status & irq_en);

  always_comb begin
    bus.rdata = '0;
    if (chan == GLOBAL_CHAN) begin
      if (rsel == REG_STATUS) bus.rdata[NUM_CH-1:0] = status;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (chan == 3'(i)) bus.rdata = ch_rdata[i];
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed and randomized self-checking bench for timer_bank
module tb_timer_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 32;
  localparam int PSC_W  = 8;
  localparam bit [31:0] CNT_MASK = (CNT_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);
  localparam int PSC_MASK = (1 << PSC_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] cnt_out;
  logic              irq;

  timer_bank_if bus();

  timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cnt_out (cnt_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  int cyc = 0;
  int p0[$];
  int p1[$];
  int t1[$];
  logic prev1 = 1'b0;

  // Reference state: what the spec says each channel holds.
  bit              m_en    [NUM_CH];
  bit [1:0]        m_mode  [NUM_CH];
  bit              m_irqen [NUM_CH];
  int              m_psc   [NUM_CH];
  bit [31:0]       m_load  [NUM_CH];
  bit [31:0]       m_cmp   [NUM_CH];
  bit [31:0]       m_count [NUM_CH];
  int              m_left  [NUM_CH];
  bit              m_sq    [NUM_CH];
  bit              m_pulse [NUM_CH];
  bit [NUM_CH-1:0] m_status = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_irqen[c] = 0; m_psc[c] = 0;
      m_load[c] = 0; m_cmp[c] = 0; m_count[c] = 0; m_left[c] = 1;
      m_sq[c] = 0; m_pulse[c] = 0;
    end
    m_status = '0;
  endfunction

  function automatic void model_step(input logic w, input logic [4:0] a, input logic [31:0] d);
    int chan;
    int r;
    bit [NUM_CH-1:0] term;
    bit [NUM_CH-1:0] clr;
    chan = int'(a[4:2]);
    r = int'(a[1:0]);
    term = '0;
    clr = '0;
    if (w && chan == 7 && r == 0) clr = d[NUM_CH-1:0];
    for (int c = 0; c < NUM_CH; c++) begin
      bit ctrl_w;
      ctrl_w = w && chan == c && r == 0;
      m_pulse[c] = 0;
      if (w && chan == c && r == 1) m_load[c] = d & CNT_MASK;
      if (w && chan == c && r == 2) m_cmp[c] = d & CNT_MASK;
      if (ctrl_w) begin
        if (!m_en[c] && d[0]) m_count[c] = m_load[c];
        m_en[c] = d[0];
        m_mode[c] = d[2:1];
        m_irqen[c] = d[3];
        m_psc[c] = int'(d >> 8) & PSC_MASK;
        m_left[c] = m_psc[c] + 1;
        m_sq[c] = 0;
      end else if (m_en[c]) begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          m_left[c] = m_psc[c] + 1;
          if (m_count[c] != 0) begin
            m_count[c]--;
          end else begin
            term[c] = 1;
            if (m_mode[c] == 0) m_en[c] = 0;
            else m_count[c] = m_load[c];
            if (m_mode[c] <= 1) m_pulse[c] = 1;
            if (m_mode[c] == 3) m_sq[c] = !m_sq[c];
          end
        end
      end else begin
        m_sq[c] = 0;
      end
    end
    m_status = (m_status & ~clr) | term;
  endfunction

  function automatic bit [31:0] model_read(input logic [4:0] a);
    int chan;
    int r;
    chan = int'(a[4:2]);
    r = int'(a[1:0]);
    if (chan == 7) return (r == 0) ? 32'(m_status) : 32'd0;
    if (chan >= NUM_CH) return 32'd0;
    case (r)
      0: return (32'(m_psc[chan]) << 8) | (32'(m_irqen[chan]) << 3) | (32'(m_mode[chan]) << 1) | 32'(m_en[chan]);
      1: return m_load[chan];
      2: return m_cmp[chan];
      default: return m_count[chan];
    endcase
  endfunction

  function automatic bit [NUM_CH-1:0] model_cnt_out();
    bit [NUM_CH-1:0] o;
    o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (m_mode[c])
        2'd0, 2'd1: o[c] = m_pulse[c];
        2'd2:       o[c] = m_en[c] && (m_count[c] < m_cmp[c]);
        default:    o[c] = m_en[c] && m_sq[c];
      endcase
    end
    return o;
  endfunction

  function automatic bit model_irq();
    bit v;
    v = 0;
    for (int c = 0; c < NUM_CH; c++) v = v | (m_status[c] & m_irqen[c]);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step(bus.we, bus.addr, bus.wdata);
  end

  always @(negedge clk) begin
    cyc++;
    if (cnt_out[0]) p0.push_back(cyc);
    if (cnt_out[1]) p1.push_back(cyc);
    if (cnt_out[1] !== prev1) t1.push_back(cyc);
    prev1 = cnt_out[1];
    if (chk_on) begin
      check("model_cnt_out", 32'(cnt_out), 32'(model_cnt_out()));
      check("model_irq", 32'(irq), 32'(model_irq()));
      check("model_rdata", bus.rdata, model_read(bus.addr));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    bus.we = 1'b1;
    bus.addr = 5'(ch * 4 + r);
    bus.wdata = d;
    @(negedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] v);
    bus.addr = 5'(ch * 4 + r);
    @(negedge clk);
    v = bus.rdata;
    #1;
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  initial begin
    logic [31:0] v;
    int w;
    int k;
    int h;
    int ch;
    int r;
    logic [31:0] d;

    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    idle(3);
    rst = 1'b0;
    chk_on = 1'b1;

    // Reset state: every address reads zero.
    for (int a = 0; a < 32; a++) begin
      rd(a / 4, a % 4, v);
      check("reset_read", v, 32'd0);
    end
    check("reset_cnt_out", 32'(cnt_out), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);

    // One-shot, LOAD=5, psc=0: single pulse 6 clk after the enabling edge.
    wr(0, 1, 32'd5);
    p0.delete();
    wr(0, 0, 32'h9);
    w = cyc;
    idle(20);
    check("oneshot_pulses", 32'(p0.size()), 32'd1);
    check("oneshot_delay", 32'(qget(p0, 0) - w), 32'd6);
    rd(7, 0, v);
    check("oneshot_status", v, 32'd1);
    check("oneshot_irq", 32'(irq), 32'd1);
    rd(0, 0, v);
    check("oneshot_en_clear", v, 32'h8);
    wr(7, 0, 32'd1);
    check("status_clear_irq", 32'(irq), 32'd0);

    // Auto-reload, psc=3, LOAD=2: 12 clk period, then LOAD=4 -> 20 clk.
    wr(1, 1, 32'd2);
    p1.delete();
    wr(1, 0, 32'h303);
    w = cyc;
    idle(62);
    check("reload_count", 32'(p1.size()), 32'd5);
    check("reload_first", 32'(qget(p1, 0) - w), 32'd12);
    for (int i = 1; i < 5; i++) check("reload_period", 32'(qget(p1, i) - qget(p1, i - 1)), 32'd12);
    k = p1.size();
    wr(1, 1, 32'd4);
    idle(60);
    check("reload_inflight", 32'(qget(p1, k) - qget(p1, k - 1)), 32'd12);
    check("reload_new1", 32'(qget(p1, k + 1) - qget(p1, k)), 32'd20);
    check("reload_new2", 32'(qget(p1, k + 2) - qget(p1, k + 1)), 32'd20);

    // PWM on ch2, LOAD=9, CMP=3.
    wr(2, 1, 32'd9);
    wr(2, 2, 32'd3);
    wr(2, 0, 32'h5);
    idle(2);
    h = 0;
    repeat (100) begin @(negedge clk); if (cnt_out[2]) h++; #1; end
    check("pwm_duty", 32'(h), 32'd30);
    wr(2, 2, 32'd0);
    h = 0;
    repeat (20) begin @(negedge clk); if (cnt_out[2]) h++; #1; end
    check("pwm_cmp0", 32'(h), 32'd0);
    wr(2, 2, 32'd15);
    h = 0;
    repeat (20) begin @(negedge clk); if (cnt_out[2]) h++; #1; end
    check("pwm_cmp_big", 32'(h), 32'd20);

    // Square wave on ch1, LOAD=4: toggles every 5 clk.
    wr(1, 0, 32'd0);
    wr(1, 1, 32'd4);
    t1.delete();
    wr(1, 0, 32'h7);
    w = cyc;
    idle(22);
    check("square_first", 32'(qget(t1, 0) - w), 32'd5);
    for (int i = 1; i < 4; i++) check("square_period", 32'(qget(t1, i) - qget(t1, i - 1)), 32'd5);
    for (int i = 0; i < 20 && !cnt_out[1]; i++) idle(1);
    check("square_wait_high", 32'(cnt_out[1]), 32'd1);
    wr(1, 0, 32'd0);
    check("square_disable", 32'(cnt_out[1]), 32'd0);

    // STATUS clear on the same edge as a terminal event: set wins.
    wr(0, 1, 32'd3);
    wr(0, 0, 32'h9);
    idle(3);
    wr(7, 0, 32'd1);
    rd(7, 0, v);
    check("clear_vs_set", v & 32'd1, 32'd1);
    check("clear_vs_set_irq", 32'(irq), 32'd1);

    // Reset during a running count.
    wr(1, 1, 32'd3);
    wr(1, 0, 32'h3);
    idle(2);
    rst = 1'b1;
    idle(1);
    check("rst_cnt_out", 32'(cnt_out), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    p0.delete();
    p1.delete();
    idle(20);
    check("rst_no_pulse", 32'(p0.size() + p1.size()), 32'd0);
    rd(1, 0, v);
    check("rst_ctrl", v, 32'd0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      ch = $urandom_range(0, 7);
      r = $urandom_range(0, 3);
      d = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        if (r == 0 && ch != 7) d[15:8] = 8'($urandom_range(0, 3));
        if ((r == 1 || r == 2) && $urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 12));
        wr(ch, r, d);
      end else begin
        bus.addr = 5'(ch * 4 + r);
        idle(1);
      end
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
